// File: rtl/cache_controller.sv
// Cache controller: write-back, write-allocate miss handling sequencer.
// Every output is registered, so a response decided in one cycle is seen in the next.
// Statistics counters saturate at all-ones instead of wrapping.
module cache_controller #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req_valid,
   input  logic                 req_type,
   input  logic                 hit,
   input  logic                 dirty_bit,
   input  logic                 mem_ready,
   output logic                 read_en_cache,
   output logic                 write_en_cache,
   output logic                 refill,
   output logic                 read_en_mem,
   output logic                 write_en_mem,
   output logic                 done_cache,
   output logic                 stall,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COMPARE   = 3'd1,
      WRITEBACK = 3'd2,
      ALLOCATE  = 3'd3,
      REFILL    = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic                 refilled_q, refilled_d;
   logic                 read_en_cache_q, read_en_cache_d;
   logic                 write_en_cache_q, write_en_cache_d;
   logic                 refill_q, refill_d;
   logic                 read_en_mem_q, read_en_mem_d;
   logic                 write_en_mem_q, write_en_mem_d;
   logic                 done_cache_q, done_cache_d;
   logic                 stall_q, stall_d;
   logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
   logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;
   logic [CNT_WIDTH-1:0] wb_count_q, wb_count_d;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // Next-state, completion, counter updates and the registered outputs for the coming cycle
   always_comb begin
      state_d          = state_q;
      refilled_d       = refilled_q;
      done_cache_d     = 1'b0;
      write_en_cache_d = 1'b0;
      hit_count_d      = hit_count_q;
      miss_count_d     = miss_count_q;
      wb_count_d       = wb_count_q;
      case (state_q)
         IDLE: begin
            refilled_d = 1'b0;
            if (cpu_req_valid) begin
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (hit) begin
               done_cache_d     = 1'b1;
               write_en_cache_d = req_type;
               state_d          = IDLE;
               if (!refilled_q) begin
                  hit_count_d = sat_inc(hit_count_q);
               end
            end else begin
               miss_count_d = sat_inc(miss_count_q);
               state_d      = dirty_bit ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            if (mem_ready) begin
               wb_count_d = sat_inc(wb_count_q);
               state_d    = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (mem_ready) begin
               state_d = REFILL;
            end
         end
         REFILL: begin
            refilled_d = 1'b1;
            state_d    = COMPARE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      read_en_cache_d  = (state_d == COMPARE);
      read_en_mem_d    = (state_d == ALLOCATE);
      write_en_mem_d   = (state_d == WRITEBACK);
      refill_d         = (state_d == REFILL);
      write_en_cache_d = write_en_cache_d | (state_d == REFILL);
      stall_d          = (state_d != IDLE);
   end

   // State, output and counter registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         refilled_q       <= 1'b0;
         read_en_cache_q  <= 1'b0;
         write_en_cache_q <= 1'b0;
         refill_q         <= 1'b0;
         read_en_mem_q    <= 1'b0;
         write_en_mem_q   <= 1'b0;
         done_cache_q     <= 1'b0;
         stall_q          <= 1'b0;
         hit_count_q      <= '0;
         miss_count_q     <= '0;
         wb_count_q       <= '0;
      end else begin
         state_q          <= state_d;
         refilled_q       <= refilled_d;
         read_en_cache_q  <= read_en_cache_d;
         write_en_cache_q <= write_en_cache_d;
         refill_q         <= refill_d;
         read_en_mem_q    <= read_en_mem_d;
         write_en_mem_q   <= write_en_mem_d;
         done_cache_q     <= done_cache_d;
         stall_q          <= stall_d;
         hit_count_q      <= hit_count_d;
         miss_count_q     <= miss_count_d;
         wb_count_q       <= wb_count_d;
      end
   end

   assign read_en_cache  = read_en_cache_q;
   assign write_en_cache = write_en_cache_q;
   assign refill         = refill_q;
   assign read_en_mem    = read_en_mem_q;
   assign write_en_mem   = write_en_mem_q;
   assign done_cache     = done_cache_q;
   assign stall          = stall_q;
   assign hit_count      = hit_count_q;
   assign miss_count     = miss_count_q;
   assign wb_count       = wb_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: directed requests with a scoreboard-driven monitor.
// Counters are narrowed to 3 bits so saturation is reached with a handful of hits.
module tb_cache_controller;

   localparam int CW   = 3;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req_valid = 1'b0;
   logic          req_type = 1'b0;
   logic          hit = 1'b0;
   logic          dirty_bit = 1'b0;
   logic          mem_ready = 1'b0;
   logic          read_en_cache, write_en_cache, refill, read_en_mem, write_en_mem;
   logic          done_cache, stall;
   logic [CW-1:0] hit_count, miss_count, wb_count;

   cache_controller #(.CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_req_valid (cpu_req_valid),
      .req_type      (req_type),
      .hit           (hit),
      .dirty_bit     (dirty_bit),
      .mem_ready     (mem_ready),
      .read_en_cache (read_en_cache),
      .write_en_cache(write_en_cache),
      .refill        (refill),
      .read_en_mem   (read_en_mem),
      .write_en_mem  (write_en_mem),
      .done_cache    (done_cache),
      .stall         (stall),
      .hit_count     (hit_count),
      .miss_count    (miss_count),
      .wb_count      (wb_count)
   );

   typedef struct {
      int lat;
      bit weCache;
      int rdCyc;
      int wrCyc;
      int hits;
      int misses;
      int wbs;
   } exp_t;

   exp_t sbQ[$];
   int   vectorsApplied = 0;
   int   miscompares = 0;
   int   expHits = 0;
   int   expMisses = 0;
   int   expWbs = 0;

   // Free-running clock
   always #5 clk = ~clk;

   // Absolute time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      vectorsApplied++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int satInc(input int v);
      return (v >= MAXC) ? MAXC : v + 1;
   endfunction

   // Monitor: tracks each transaction from COMPARE entry and checks it against the scoreboard at done_cache
   int  cycle = 0;
   bit  busy = 1'b0;
   int  startCycle = 0;
   int  rdCyc = 0;
   int  wrCyc = 0;
   int  overlapCyc = 0;
   int  stallLow = 0;
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (!busy && read_en_cache) begin
               busy       = 1'b1;
               startCycle = cycle;
               rdCyc      = 0;
               wrCyc      = 0;
               overlapCyc = 0;
               stallLow   = 0;
            end
            if (busy && !done_cache) begin
               rdCyc      += int'(read_en_mem);
               wrCyc      += int'(write_en_mem);
               overlapCyc += int'(read_en_mem && write_en_mem);
               stallLow   += int'(!stall);
            end
            if (done_cache) begin
               if (sbQ.size() == 0) begin
                  checkOutput("unexpected_done", 1, 0);
               end else begin
                  exp_t e;
                  e = sbQ.pop_front();
                  checkOutput("latency", busy ? cycle - startCycle : -1, e.lat);
                  checkOutput("write_en_cache_at_done", write_en_cache, e.weCache);
                  checkOutput("refill_at_done", refill, 0);
                  checkOutput("stall_at_done", stall, 0);
                  checkOutput("stall_low_while_busy", stallLow, 0);
                  checkOutput("read_en_mem_cycles", rdCyc, e.rdCyc);
                  checkOutput("write_en_mem_cycles", wrCyc, e.wrCyc);
                  checkOutput("mem_enable_overlap", overlapCyc, 0);
                  checkOutput("hit_count", hit_count, e.hits);
                  checkOutput("miss_count", miss_count, e.misses);
                  checkOutput("wb_count", wb_count, e.wbs);
               end
               busy = 1'b0;
            end
         end
      end
   end

   // Issue one request, act as cache tag store and main memory, and push the expected result
   task automatic applyStimulus(input bit rt, input bit isMiss, input bit dirty, input int n,
                                input bit spurious, input int lat, input int rdc, input int wrc);
      exp_t e;
      bit   seenDone = 1'b0;
      int   wbCnt = 0;
      int   rdCnt = 0;
      if (isMiss) begin
         expMisses = satInc(expMisses);
         if (dirty) expWbs = satInc(expWbs);
      end else begin
         expHits = satInc(expHits);
      end
      e.lat = lat; e.weCache = rt; e.rdCyc = rdc; e.wrCyc = wrc;
      e.hits = expHits; e.misses = expMisses; e.wbs = expWbs;
      sbQ.push_back(e);
      @(negedge clk);
      cpu_req_valid = 1'b1;
      req_type      = rt;
      hit           = !isMiss;
      dirty_bit     = dirty;
      mem_ready     = spurious;
      for (int k = 0; k < 60 && !seenDone; k++) begin
         @(negedge clk);
         if (done_cache) begin
            seenDone = 1'b1;
         end else begin
            wbCnt     = write_en_mem ? wbCnt + 1 : 0;
            rdCnt     = read_en_mem ? rdCnt + 1 : 0;
            mem_ready = spurious || (write_en_mem && wbCnt == n) || (read_en_mem && rdCnt == n);
            if (refill) hit = 1'b1;
         end
      end
      cpu_req_valid = 1'b0;
      hit           = 1'b0;
      mem_ready     = 1'b0;
      dirty_bit     = 1'b0;
      if (!seenDone) begin
         checkOutput("request_timeout", 0, 1);
         void'(sbQ.pop_back());
      end
   endtask

   // Check that every output and counter sits at zero
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_read_en_cache"}, read_en_cache, 0);
      checkOutput({tag, "_write_en_cache"}, write_en_cache, 0);
      checkOutput({tag, "_refill"}, refill, 0);
      checkOutput({tag, "_read_en_mem"}, read_en_mem, 0);
      checkOutput({tag, "_write_en_mem"}, write_en_mem, 0);
      checkOutput({tag, "_done_cache"}, done_cache, 0);
      checkOutput({tag, "_stall"}, stall, 0);
      checkOutput({tag, "_hit_count"}, hit_count, 0);
      checkOutput({tag, "_miss_count"}, miss_count, 0);
      checkOutput({tag, "_wb_count"}, wb_count, 0);
   endtask

   // Start a clean miss, hit reset while memory is being read, and check the transaction is dropped
   task automatic resetInAllocate();
      bit seenRd = 1'b0;
      @(negedge clk);
      cpu_req_valid = 1'b1;
      req_type      = 1'b0;
      hit           = 1'b0;
      dirty_bit     = 1'b0;
      for (int k = 0; k < 10 && !seenRd; k++) begin
         @(negedge clk);
         seenRd = read_en_mem;
      end
      checkOutput("reached_allocate", seenRd, 1);
      rst           = 1'b1;
      cpu_req_valid = 1'b0;
      @(negedge clk);
      checkAllZero("reset_in_allocate");
      @(negedge clk);
      rst       = 1'b0;
      expHits   = 0;
      expMisses = 0;
      expWbs    = 0;
   endtask

   // Directed sequence
   initial begin
      repeat (2) @(negedge clk);
      checkAllZero("after_reset");
      rst = 1'b0;
      // rt, miss, dirty, n, spurious mem_ready, latency, read_en_mem cycles, write_en_mem cycles
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 3, 1'b0, 6, 3, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 2, 1'b0, 7, 2, 2);
      applyStimulus(1'b1, 1'b1, 1'b0, 3, 1'b0, 6, 3, 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1, 1'b0, 5, 1, 1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 0, 0);
      end
      resetInAllocate();
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 0, 0);
      repeat (4) @(negedge clk);
      checkOutput("scoreboard_drained", sbQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of the hit/miss/writeback statistics counters.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have port cpu_req_valid  input  1: processor request present; tag/index/offset/data held stable by the requester until done_cache.
REQ-005 SHALL have port req_type  input  1: 0 = read, 1 = write.
REQ-006 SHALL have port hit  input  1: tag match from the cache memory, either way.
REQ-007 SHALL have port dirty_bit  input  1: dirty bit of the PLRU victim way of the addressed set.
REQ-008 SHALL have port mem_ready  input  1: main memory has completed the current read or write.
REQ-009 SHALL have port read_en_cache  output  1: cache lookup/read enable.
REQ-010 SHALL have port write_en_cache  output  1: cache write enable; word write on a hit, block fill from data_in_mem during refill.
REQ-011 SHALL have port refill  output  1: selects a block fill into the victim way instead of a word write.
REQ-012 SHALL have port read_en_mem  output  1: block read request to main memory.
REQ-013 SHALL have port write_en_mem  output  1: dirty_block_out writeback request to main memory.
REQ-014 SHALL have port done_cache  output  1: one-cycle completion pulse to the processor.
REQ-015 SHALL have port stall  output  1: high whenever a request is accepted but not complete.
REQ-016 SHALL have ports hit_count, miss_count, wb_count  output  CNT_WIDTH each: statistics counters.

Function
REQ-017 SHALL implement the states IDLE, COMPARE, WRITEBACK, ALLOCATE and REFILL.
REQ-018 IDLE: SHALL move to COMPARE on cpu_req_valid=1 and otherwise remain in IDLE; all enables SHALL be 0.
REQ-019 COMPARE: SHALL assert read_en_cache; hit=1 with req_type=0 SHALL pulse done_cache and return to IDLE.
REQ-020 COMPARE: hit=1 with req_type=1 SHALL assert write_en_cache (refill=0) and done_cache in that same cycle, then return to IDLE.
REQ-021 COMPARE: hit=0 with dirty_bit=1 SHALL go to WRITEBACK; hit=0 with dirty_bit=0 SHALL go to ALLOCATE.
REQ-022 WRITEBACK: SHALL hold write_en_mem=1 until the cycle mem_ready=1, then go to ALLOCATE with write_en_mem deasserted the following cycle.
REQ-023 ALLOCATE: SHALL hold read_en_mem=1 until mem_ready=1, then go to REFILL.
REQ-024 REFILL: SHALL assert write_en_cache=1 and refill=1 for exactly one cycle, then return to COMPARE; the re-lookup then hits and completes per REQ-019 or REQ-020.
REQ-025 Miss latency SHALL be, with memory responding after N cycles: clean = 1 + N + 1 + 1 cycles from COMPARE entry to done_cache; dirty adds N more.
REQ-026 read_en_mem and write_en_mem SHALL never be high in the same cycle.
REQ-027 hit_count SHALL increment on each done_cache whose request needed no refill; miss_count SHALL increment on each COMPARE to WRITEBACK/ALLOCATE transition; wb_count SHALL increment on each WRITEBACK exit.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 stall SHALL be 1 in COMPARE, WRITEBACK, ALLOCATE and REFILL, except in the cycle done_cache=1.
REQ-030 mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-031 cpu_req_valid held high after done_cache SHALL start a new request: IDLE one cycle, then COMPARE. There is no back-to-back bypass.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE, clear all counters and drive every output to 0 in the next cycle.
REQ-033 rst mid-operation (any state) SHALL abandon the transaction with no done_cache and drop memory requests the next cycle.
REQ-034 rst SHALL take priority over every other input.

Verification
REQ-035 Read hit: valid, req_type=0, hit=1 -> done_cache 1 cycle after COMPARE entry, no memory enables, hit_count=1.
REQ-036 Write hit: req_type=1, hit=1 -> write_en_cache=1, refill=0 and done_cache in the same cycle; hit_count increments.
REQ-037 Clean read miss: hit=0, dirty_bit=0, mem_ready after 3 cycles -> read_en_mem high 3 cycles, one refill pulse, done_cache 6 cycles after COMPARE entry; miss_count=1, wb_count=0.
REQ-038 Dirty miss: hit=0, dirty_bit=1, mem_ready after 2 cycles each -> write_en_mem then read_en_mem, never overlapping; wb_count=1, miss_count=1.
REQ-039 Reset in ALLOCATE -> next cycle read_en_mem=0, state IDLE, counters 0, no done_cache.
REQ-040 Saturation: counter forced to all-ones, one more hit -> hit_count remains all-ones.
